proj_kmer_seq_ctrl: RTL and testbench
=====================================

PROJ_KMER_SEQ_CTRL -- requirements
Module: proj_kmer_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 2, bits per nucleotide symbol.
REQ-002 SHALL have parameter KMER_LEN, default 16, symbols per k-mer.
REQ-003 SHALL have parameter CNT_W, default 16, width of k-mer counters.
REQ-004 SHALL have ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input symbol valid
in_ready  out  1  block accepts a symbol this cycle
in_data  in  DATA_BITS  nucleotide symbol
in_last  in  1  accepted symbol is the last of its sequence
kmer_valid  out  1  kmer_data holds a complete k-mer
kmer_ready  in  1  downstream (hash stage) accepts the k-mer
kmer_data  out  KMER_LEN x DATA_BITS  packed k-mer; element 0 is the newest symbol
kmer_idx  out  CNT_W  zero-based index of the presented k-mer within its sequence
seq_done  out  1  one-cycle pulse: sequence finished
seq_kmer_cnt  out  CNT_W  k-mers emitted for the finished sequence; valid while seq_done=1

Function
REQ-005 Symbol accepted only when in_valid && in_ready; in_ready = (state != FLUSH) && (!kmer_valid || kmer_ready).
REQ-006 Each accepted symbol shifts into the window: element i takes element i-1, element 0 takes in_data.
REQ-007 FSM states: FILL, STREAM, FLUSH, DONE.
REQ-008 FILL: fill counter counts accepted symbols; on the KMER_LEN-th accepted symbol go to STREAM and set kmer_valid the next cycle.
REQ-009 STREAM: every accepted symbol sets kmer_valid the next cycle with the updated window; k-mers overlap with stride 1.
REQ-010 kmer_valid, kmer_data and kmer_idx SHALL stay stable while kmer_valid && !kmer_ready.
REQ-011 kmer_valid && kmer_ready with no new accept: kmer_valid deasserts the next cycle; with a simultaneous accept in STREAM, kmer_valid stays high and kmer_idx increments by 1.
REQ-012 Accepted symbol with in_last in STREAM, or completing the window in FILL: go to FLUSH; stay until the final k-mer handshakes, then go to DONE.
REQ-013 Accepted symbol with in_last in FILL before the window is complete: go directly to DONE; no k-mer is emitted.
REQ-014 DONE lasts exactly one cycle: seq_done=1, seq_kmer_cnt = k-mers handshaken in that sequence, in_ready=0.
REQ-015 DONE also clears the window, fill counter and kmer_idx; next state FILL.
REQ-016 No k-mer spans two sequences.
REQ-017 kmer_idx and seq_kmer_cnt saturate at 2^CNT_W-1 and do not wrap.
REQ-018 in_valid=0 inserts bubbles only; window contents and the FSM state hold.

Reset
REQ-019 rst=1 at a clock edge: state=FILL, window=0, counters=0, kmer_valid=0, seq_done=0, in_ready=0 during reset, regardless of the state when reset asserts.
REQ-020 The first cycle after reset deasserts: in_ready=1; any in-flight k-mer is discarded without a seq_done.

Structure
REQ-021 proj_pkg SHALL hold the FSM state enum typedef and the default DATA_BITS and KMER_LEN constants.
REQ-022 The window shift register with shift enable and synchronous clear is sub-module proj_kmer_window; the FSM, counters and handshake logic stay in proj_kmer_seq_ctrl.
REQ-023 kmer_data SHALL be driven directly from window registers, with no combinational path from in_data.

Verification
REQ-024 KMER_LEN=16, 20 symbols streamed, kmer_ready=1, last on symbol 20 -> 5 k-mers at idx 0..4, first one cycle after symbol 16; seq_done with seq_kmer_cnt=5.
REQ-025 kmer_ready=0 for 3 cycles while a k-mer is presented -> in_ready=0 and kmer_data/kmer_idx stable for those 3 cycles; no symbol lost after release.
REQ-026 10-symbol sequence with in_last on symbol 10 -> no kmer_valid; seq_done one cycle later with seq_kmer_cnt=0.
REQ-027 Two back-to-back 17-symbol sequences -> 2 k-mers each, idx restarts at 0, and the second sequence's first k-mer contains none of the first sequence's symbols.
REQ-028 rst during STREAM after 3 k-mers -> kmer_valid=0 next cycle, no seq_done, then a fresh 16-symbol fill yields idx 0.
REQ-029 Random in_valid and kmer_ready gaps -> a scoreboard sliding-window model matches every k-mer and its count.

Source files
------------

// File: rtl/proj_pkg.sv
// proj_pkg: shared types and default constants for the k-mer sequencing block.
//   kmer_state_e  - controller FSM state encoding
//   DEF_DATA_BITS - default bits per nucleotide symbol
//   DEF_KMER_LEN  - default symbols per k-mer
package proj_pkg;
  localparam int DEF_DATA_BITS = 2;
  localparam int DEF_KMER_LEN  = 16;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } kmer_state_e;
endpackage

// File: rtl/proj_kmer_window.sv
// proj_kmer_window: KMER_LEN-deep symbol shift register.
//   clk    - rising-edge clock
//   clr_i  - synchronous clear (dominates en_i)
//   en_i   - shift enable: element 0 takes din_i, element i takes element i-1
//   din_i  - incoming symbol
//   win_o  - registered window, element 0 is the newest symbol
module proj_kmer_window
  import proj_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int KMER_LEN  = DEF_KMER_LEN
) (
  input  logic                               clk,
  input  logic                               clr_i,
  input  logic                               en_i,
  input  logic [DATA_BITS-1:0]               din_i,
  output logic [KMER_LEN-1:0][DATA_BITS-1:0] win_o
);
  logic [KMER_LEN-1:0][DATA_BITS-1:0] win_q, win_d;

  always_comb begin
    win_d    = win_q;
    win_d[0] = din_i;
    for (int i = 1; i < KMER_LEN; i++) win_d[i] = win_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (clr_i)     win_q <= '0;
    else if (en_i) win_q <= win_d;
  end

  assign win_o = win_q;
endmodule

// File: rtl/proj_kmer_seq_ctrl.sv
// proj_kmer_seq_ctrl: turns a stream of nucleotide symbols into overlapping
// stride-1 k-mers, one sequence at a time, with valid/ready on both sides.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - symbol handshake; in_data symbol, in_last ends sequence
//   kmer_valid/ready    - k-mer handshake; kmer_data window (elem 0 newest),
//                         kmer_idx zero-based k-mer index in the sequence
//   seq_done            - one-cycle pulse at sequence end, with seq_kmer_cnt
//                         = number of k-mers handshaken for that sequence
module proj_kmer_seq_ctrl
  import proj_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int KMER_LEN  = DEF_KMER_LEN,
  parameter int CNT_W     = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_BITS-1:0]               in_data,
  input  logic                               in_last,
  output logic                               kmer_valid,
  input  logic                               kmer_ready,
  output logic [KMER_LEN-1:0][DATA_BITS-1:0] kmer_data,
  output logic [CNT_W-1:0]                   kmer_idx,
  output logic                               seq_done,
  output logic [CNT_W-1:0]                   seq_kmer_cnt
);
  localparam int             FW        = $clog2(KMER_LEN + 1);
  localparam logic [FW-1:0]  FILL_LAST = FW'(KMER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  kmer_state_e      state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, idx_q, idx_d;
  logic             vld_q, vld_d;
  logic             accept, hs, win_full, emit, clr;

  assign accept   = in_valid && in_ready;
  assign hs       = vld_q && kmer_ready;
  assign win_full = (fill_q == FILL_LAST);
  // A new k-mer appears on every accept once the window is (or becomes) full.
  assign emit     = accept && ((state_q == ST_STREAM) || (state_q == ST_FILL && win_full));
  assign clr      = rst || (state_q == ST_DONE);

  proj_kmer_window #(.DATA_BITS(DATA_BITS), .KMER_LEN(KMER_LEN)) u_win (
    .clk   (clk),
    .clr_i (clr),
    .en_i  (accept),
    .din_i (in_data),
    .win_o (kmer_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FILL;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL: if (accept) begin
        if (win_full)     state_d = in_last ? ST_FLUSH : ST_STREAM;
        else if (in_last) state_d = ST_DONE;
      end
      ST_STREAM: if (accept && in_last) state_d = ST_FLUSH;
      ST_FLUSH:  if (hs) state_d = ST_DONE;
      ST_DONE:   state_d = ST_FILL;
      default:   state_d = ST_FILL;
    endcase
  end

  // Outputs; in_ready is forced low while reset is applied.
  always_comb begin
    in_ready = !rst && (state_q == ST_FILL || state_q == ST_STREAM) && (!vld_q || kmer_ready);
    seq_done = (state_q == ST_DONE);
  end

  // Counters and k-mer valid. cnt counts handshaken k-mers; a newly emitted
  // k-mer's index is the handshake count including this cycle's handshake.
  always_comb begin
    fill_d = fill_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    vld_d  = vld_q;
    if (state_q == ST_DONE) begin
      fill_d = '0;
      cnt_d  = '0;
      idx_d  = '0;
      vld_d  = 1'b0;
    end else begin
      if (accept && state_q == ST_FILL && !win_full) fill_d = fill_q + 1'b1;
      if (hs && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (emit)    begin vld_d = 1'b1; idx_d = cnt_d; end
      else if (hs) vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
    end
  end

  assign kmer_valid   = vld_q;
  assign kmer_idx     = idx_q;
  assign seq_kmer_cnt = cnt_q;
endmodule

// File: tb/tb_proj_kmer_seq_ctrl.sv
// Scoreboard bench for proj_kmer_seq_ctrl. A small CNT_W makes counter
// saturation reachable with short sequences.
module tb_proj_kmer_seq_ctrl;
  localparam int DB   = 2;
  localparam int KL   = 16;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, kmer_ready = 1;
  logic [DB-1:0] in_data = '0;
  logic in_ready, kmer_valid, seq_done;
  logic [KL-1:0][DB-1:0] kmer_data;
  logic [CW-1:0] kmer_idx, seq_kmer_cnt;

  always #5 clk = ~clk;

  proj_kmer_seq_ctrl #(.DATA_BITS(DB), .KMER_LEN(KL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .kmer_valid(kmer_valid),
    .kmer_ready(kmer_ready), .kmer_data(kmer_data), .kmer_idx(kmer_idx),
    .seq_done(seq_done), .seq_kmer_cnt(seq_kmer_cnt)
  );

  typedef struct {
    bit              is_done;
    logic [KL*DB-1:0] data;
    int              val;   // k-mer index, or k-mer count for a done event
  } ev_t;

  ev_t exp_q[$];
  logic [DB-1:0] cur[$];
  int n_cmp = 0, n_bad = 0;
  bit sb_en = 0, rand_rdy = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: every length-KL slice of the sequence, newest symbol in element 0.
  task automatic gen_seq(input int len);
    ev_t e;
    int n;
    cur.delete();
    for (int i = 0; i < len; i++) cur.push_back(DB'($urandom_range(0, (1 << DB) - 1)));
    n = (len >= KL) ? len - KL + 1 : 0;
    for (int j = 0; j < n; j++) begin
      e.is_done = 0;
      for (int i = 0; i < KL; i++) e.data[i*DB +: DB] = cur[j+KL-1-i];
      e.val = (j > CMAX) ? CMAX : j;
      exp_q.push_back(e);
    end
    e.is_done = 1;
    e.data    = '0;
    e.val     = (n > CMAX) ? CMAX : n;
    exp_q.push_back(e);
  endtask

  // Called and returns at posedge+1.
  task automatic send(input logic [DB-1:0] d, input bit last, input int gap);
    int t = 0;
    in_valid = 0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1; in_data = d; in_last = last;
    @(negedge clk);
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic send_range(input int from, input int to, input int maxgap);
    for (int i = from; i < to; i++)
      send(cur[i], i == cur.size() - 1, maxgap > 0 ? $urandom_range(0, maxgap) : 0);
  endtask

  task automatic run_seq(input int len, input int maxgap);
    gen_seq(len);
    send_range(0, len, maxgap);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 600) begin @(posedge clk); t++; end
    if (exp_q.size() != 0) begin
      chk("drain_left", exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  always @(posedge clk) if (rand_rdy) begin #1; kmer_ready = ($urandom_range(0, 3) != 0); end

  // Monitor: pops expected events on k-mer handshakes and seq_done pulses.
  logic stall_p = 0;
  logic [KL*DB-1:0] data_p;
  logic [CW-1:0] idx_p;
  always @(negedge clk) begin
    ev_t e;
    if (sb_en) begin
      if (stall_p) begin
        chk("stall_valid", kmer_valid, 1);
        chk("stall_data", kmer_data, data_p);
        chk("stall_idx", kmer_idx, idx_p);
      end
      if (kmer_valid && kmer_ready) begin
        if (exp_q.size() == 0) chk("unexpected_kmer", 1, 0);
        else begin
          e = exp_q.pop_front();
          if (e.is_done) chk("kmer_instead_of_done", 1, 0);
          else begin
            chk("kmer_data", kmer_data, e.data);
            chk("kmer_idx", kmer_idx, e.val);
          end
        end
      end
      if (seq_done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          if (!e.is_done) chk("done_before_kmers", 1, 0);
          else chk("seq_kmer_cnt", seq_kmer_cnt, e.val);
        end
      end
      stall_p = kmer_valid && !kmer_ready;
      data_p  = kmer_data;
      idx_p   = kmer_idx;
    end else stall_p = 0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KL*DB-1:0] d0;
    logic [CW-1:0] i0;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_kmer_valid", kmer_valid, 0);
    chk("rst_seq_done", seq_done, 0);
    chk("rst_kmer_data", kmer_data, 0);
    chk("rst_kmer_idx", kmer_idx, 0);
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    sb_en = 1;

    // 20 symbols: first k-mer one cycle after symbol 16, 5 k-mers total.
    gen_seq(20);
    send_range(0, 16, 0);
    @(negedge clk);
    chk("first_kmer_latency", kmer_valid, 1);
    chk("first_kmer_idx", kmer_idx, 0);
    @(posedge clk); #1;
    send_range(16, 20, 0);
    drain();

    // Downstream stall for 3 cycles with a symbol pending.
    gen_seq(20);
    kmer_ready = 0;
    send_range(0, 16, 0);
    in_valid = 1; in_data = cur[16]; in_last = 0;
    @(negedge clk);
    chk("stall_kmer_valid", kmer_valid, 1);
    d0 = kmer_data; i0 = kmer_idx;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_hold_data", kmer_data, d0);
      chk("stall_hold_idx", kmer_idx, i0);
    end
    @(posedge clk); #1;
    kmer_ready = 1;
    send_range(16, 20, 0);
    drain();

    // Short sequence: no k-mer, count 0.
    run_seq(10, 0);
    drain();

    // Back-to-back 17-symbol sequences.
    gen_seq(17);
    send_range(0, 17, 0);
    gen_seq(17);
    send_range(0, 17, 0);
    drain();

    // Long sequence: index and count saturate.
    run_seq(30, 0);
    drain();

    // Reset in STREAM after 3 k-mers.
    sb_en = 0;
    gen_seq(20);
    exp_q.delete();
    send_range(0, 18, 0);
    rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("mid_rst_kmer_valid", kmer_valid, 0);
    chk("mid_rst_seq_done", seq_done, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_done", seq_done, 0);
    end
    @(posedge clk); #1;
    sb_en = 1;
    run_seq(16, 0);
    drain();

    // Randomized gaps on both sides.
    rand_rdy = 1;
    for (int s = 0; s < 25; s++) run_seq($urandom_range(1, 36), 3);
    drain();
    @(posedge clk); #2;
    rand_rdy = 0; kmer_ready = 1;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
